// File: rtl/map_tile_server.sv
// map_tile_server: playfield wall map (fixed border + breakable interior blocks).
// Serves the VGA tile lookups, collision queries and shell-hit writes, and
// reloads the map row by row on reset or on i_reload.
// Optional feature macro: MAP_HIT_HP_EN (blocks need two hits to break).
module map_tile_server #(
    parameter int MAP_W = 40,
    parameter int MAP_H = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_reload,
    output logic       o_ready,
    input  logic [5:0] i_vga_x,
    input  logic [5:0] i_vga_y,
    output logic       o_vga_wall,
    input  logic       i_query_valid,
    input  logic [5:0] i_query_x,
    input  logic [5:0] i_query_y,
    output logic       o_query_ack,
    output logic       o_query_wall,
    input  logic       i_hit_valid,
    input  logic [5:0] i_hit_x,
    input  logic [5:0] i_hit_y,
    output logic       o_hit_ack,
    output logic       o_hit_destroyed,
    output logic [5:0] o_blocks_left
);

    localparam int XW = $clog2(MAP_W);
    localparam int YW = $clog2(MAP_H);
    localparam logic [5:0]    X_LAST = 6'(MAP_W - 1);
    localparam logic [5:0]    Y_LAST = 6'(MAP_H - 1);
    localparam logic [YW-1:0] R_LAST = YW'(MAP_H - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef logic [MAP_H-1:0][MAP_W-1:0] map_t;

    state_t        state_q, state_d;
    logic [YW-1:0] r_q, r_d;
    map_t          block_q, block_d;
`ifdef MAP_HIT_HP_EN
    map_t          dmg_q, dmg_d;
`endif
    logic [5:0]    count_q, count_d;
    logic          vga_wall_q, vga_wall_d;
    logic          query_ack_q, query_ack_d;
    logic          query_wall_q, query_wall_d;
    logic          hit_ack_q, hit_ack_d;
    logic          hit_destroyed_q, hit_destroyed_d;

    // Interior = not border and not out of range; only these tiles are stored.
    function automatic logic is_interior(input logic [5:0] x, input logic [5:0] y);
        return (x != 6'd0) && (y != 6'd0) && (x < X_LAST) && (y < Y_LAST);
    endfunction

    // One row of the reload pattern: columns x%8==4 on rows y%8 in {2,3}.
    function automatic logic [MAP_W-1:0] init_row(input logic [YW-1:0] r);
        logic [MAP_W-1:0] row;
        logic [5:0]       xv;
        logic [5:0]       yv;
        row = '0;
        yv  = 6'(r);
        for (int x = 0; x < MAP_W; x++) begin
            xv     = 6'(x);
            row[x] = is_interior(xv, yv) && (xv[2:0] == 3'd4) &&
                     ((yv[2:0] == 3'd2) || (yv[2:0] == 3'd3));
        end
        return row;
    endfunction

    function automatic logic [5:0] row_count(input logic [MAP_W-1:0] row);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < MAP_W; i++) c = c + {5'd0, row[i]};
        return c;
    endfunction

    // Interior tiles read as empty until the map is fully loaded.
    function automatic logic wall_at(input logic [5:0] x, input logic [5:0] y,
                                     input logic run, input map_t map);
        if (!is_interior(x, y)) return 1'b1;
        return run && map[y[YW-1:0]][x[XW-1:0]];
    endfunction

    logic run;
    assign run = (state_q == ST_RUN);

    // Next-state: row loader in INIT, query/hit servicing in RUN.
    always_comb begin
        state_d         = state_q;
        r_d             = r_q;
        block_d         = block_q;
`ifdef MAP_HIT_HP_EN
        dmg_d           = dmg_q;
`endif
        count_d         = count_q;
        vga_wall_d      = wall_at(i_vga_x, i_vga_y, run, block_q);
        query_ack_d     = 1'b0;
        query_wall_d    = 1'b0;
        hit_ack_d       = 1'b0;
        hit_destroyed_d = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (i_reload) begin
                    r_d     = '0;
                    count_d = '0;
                end else begin
                    block_d[r_q] = init_row(r_q);
`ifdef MAP_HIT_HP_EN
                    dmg_d[r_q]   = '0;
`endif
                    count_d      = count_q + row_count(init_row(r_q));
                    if (r_q == R_LAST) begin
                        state_d = ST_RUN;
                        r_d     = '0;
                    end else begin
                        r_d = r_q + 1'b1;
                    end
                end
            end
            default: begin
                // Query reads block_q, i.e. the value before any same-cycle hit.
                if (i_query_valid) begin
                    query_ack_d  = 1'b1;
                    query_wall_d = wall_at(i_query_x, i_query_y, 1'b1, block_q);
                end
                if (i_hit_valid) begin
                    hit_ack_d = 1'b1;
                    if (is_interior(i_hit_x, i_hit_y) &&
                        block_q[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]]) begin
`ifdef MAP_HIT_HP_EN
                        if (dmg_q[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]]) begin
                            block_d[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]] = 1'b0;
                            dmg_d[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]]   = 1'b0;
                            hit_destroyed_d = 1'b1;
                            if (count_q != 6'd0) count_d = count_q - 6'd1;
                        end else begin
                            dmg_d[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]] = 1'b1;
                        end
`else
                        block_d[i_hit_y[YW-1:0]][i_hit_x[XW-1:0]] = 1'b0;
                        hit_destroyed_d = 1'b1;
                        if (count_q != 6'd0) count_d = count_q - 6'd1;
`endif
                    end
                end
                if (i_reload) begin
                    state_d = ST_INIT;
                    r_d     = '0;
                    count_d = '0;
                end
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_INIT;
            r_q             <= '0;
            block_q         <= '0;
`ifdef MAP_HIT_HP_EN
            dmg_q           <= '0;
`endif
            count_q         <= '0;
            vga_wall_q      <= 1'b0;
            query_ack_q     <= 1'b0;
            query_wall_q    <= 1'b0;
            hit_ack_q       <= 1'b0;
            hit_destroyed_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            r_q             <= r_d;
            block_q         <= block_d;
`ifdef MAP_HIT_HP_EN
            dmg_q           <= dmg_d;
`endif
            count_q         <= count_d;
            vga_wall_q      <= vga_wall_d;
            query_ack_q     <= query_ack_d;
            query_wall_q    <= query_wall_d;
            hit_ack_q       <= hit_ack_d;
            hit_destroyed_q <= hit_destroyed_d;
        end
    end

    assign o_ready         = run;
    assign o_vga_wall      = vga_wall_q;
    assign o_query_ack     = query_ack_q;
    assign o_query_wall    = query_wall_q;
    assign o_hit_ack       = hit_ack_q;
    assign o_hit_destroyed = hit_destroyed_q;
    assign o_blocks_left   = count_q;

endmodule
